data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised single-port data memory for the MIPS datapath. It replaces the plain word RAM.
//  Adds byte, halfword and word loads/stores with sign or zero extension, and misalignment detection.
//  Adds an optional registered read port and a hardware clear of the whole array after reset.
//  Sits between the ALU address/rt store-data path and the writeback mux.
// PARAMETERS
//  DEPTH_LOG2      8   log2 of memory depth in 32-bit words (default 256 words = 1 KiB)
//  READ_REG        0   0: combinational read (single-cycle core); 1: registered read, 1-cycle latency
//  CLEAR_ON_RESET  1   1: zero every word after reset, busy meanwhile; 0: contents undefined, no clear
// PORTS
//  clk       in   1   clock; all state updates on the rising edge
//  rst       in   1   reset, asynchronous, active-high
//  req       in   1   access request, qualified by ready
//  we        in   1   1 = store, 0 = load
//  size      in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  sext      in   1   loads only: 1 = sign-extend, 0 = zero-extend (ignored for word)
//  addr      in   32  byte address
//  d_in      in   32  store data, right-justified (sb uses [7:0], sh uses [15:0])
//  d_out     out  32  load data, extended to 32 bits
//  valid     out  1   d_out holds the result of an accepted load
//  misalign  out  1   current request is misaligned or illegal-size
//  ready     out  1   block accepts requests (= ~busy)
//  busy      out  1   clear sequence in progress
// BEHAVIOUR
//  - Reset (async): FSM -> CLEAR if CLEAR_ON_RESET, else IDLE.
//    Reset values: clear index = 0, busy = CLEAR_ON_RESET, ready = ~busy, valid = 0, d_out reg = 0.
//  - Reset does not otherwise alter array contents.
//  - CLEAR state: writes 0 to word[idx] each cycle, idx 0..DEPTH-1.
//    Moves to IDLE on the edge after writing DEPTH-1, so busy is high for exactly DEPTH cycles after rst falls.
//    req is ignored while busy.
//  - Reset asserted mid-clear restarts the clear at idx 0.
//  - IDLE: a request is accepted when req & ready.
//  - Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
//  - Byte order is little-endian: lane k = bits [8k+7:8k] at addr[1:0] = k.
//  - misalign = req & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)).
//    Combinational, request cycle, both READ_REG modes. Forced to 0 while busy.
//  - Store (accepted, we=1, not misaligned): on the rising edge, write only the addressed lanes.
//    Byte: d_in[7:0] -> lane addr[1:0]. Half: d_in[15:0] -> lanes addr[1]*2, +1. Word: all lanes.
//    A misaligned store writes nothing.
//  - Load, READ_REG=0: d_out is combinational from the array; valid = req & ~we & ready.
//  - Load, READ_REG=1: d_out and valid are registered; valid is high the cycle after acceptance.
//    valid = 0 after cycles with no accepted load; d_out holds its last value.
//  - Load data: select the lane(s), then extend per sext. A misaligned load returns d_out = 0 with valid = 1.
//  - Store then load of the same word on the next cycle returns the new data.
//    The port is single-ported, so there are no same-cycle read/write hazards.
//  - When idle or on a store, valid = 0; d_out is 0 in READ_REG=0 mode.
// TESTING
//  1 rst 1->0, DEPTH_LOG2=8, CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles; then lw 0x14 -> 0x00000000.
//  2 sw addr 0x4 d_in 0x43214312, then lw 0x4 -> d_out 0x43214312.
//    READ_REG=0: same cycle. READ_REG=1: valid 1 cycle later.
//  3 After 2: sb addr 0x5 d_in 0x000000FF -> lw 0x4 = 0x4321FF12; lb 0x5 sext=1 -> 0xFFFFFFFF; lbu 0x5 -> 0x000000FF.
//  4 sh addr 0x6 d_in 0x8001 -> lh 0x6 sext=1 -> 0xFFFF8001; lw 0x4 = 0x8001FF12.
//    sh 0x7 -> misalign=1, word unchanged. lw 0x2 -> misalign=1, d_out 0.
//  5 Aliasing: sw addr 0x400 d_in 0xDEADBEEF -> lw 0x0 returns 0xDEADBEEF.
//  6 rst pulsed at clear idx 100 -> busy restarts; 256 cycles after rst falls ready=1.
//    req issued while busy has no effect (lw afterwards reads 0).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Single-port data memory for the MIPS datapath. Supports byte, halfword and
//   word loads/stores (little-endian lanes), sign/zero extension on sub-word
//   loads, misalignment detection, an optional registered read port and a
//   hardware clear of the whole array after reset.
//
// Parameters
//   DEPTH_LOG2      log2 of depth in 32-bit words
//   READ_REG        0: combinational read, 1: registered read (1-cycle latency)
//   CLEAR_ON_RESET  1: zero every word after reset (busy meanwhile)
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_req       access request, qualified by o_ready
//   i_we        1 = store, 0 = load
//   i_size      00 byte, 01 halfword, 10 word, 11 illegal
//   i_sext      loads: 1 = sign-extend, 0 = zero-extend
//   i_addr      byte address
//   i_d_in      store data, right-justified
//   o_d_out     load data, extended to 32 bits
//   o_valid     o_d_out holds the result of an accepted load
//   o_misalign  current request is misaligned or illegal-size
//   o_ready     block accepts requests
//   o_busy      clear sequence in progress
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int DEPTH_LOG2     = 8,
   parameter int READ_REG       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_d_in,
   output logic [31:0] o_d_out,
   output logic        o_valid,
   output logic        o_misalign,
   output logic        o_ready,
   output logic        o_busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic [DEPTH_LOG2-1:0]   w_next_idx;
   logic [31:0]             r_mem [DEPTH];

   logic                    w_busy;
   logic                    w_ready;
   logic                    w_misalign;
   logic                    w_accept;
   logic                    w_store;
   logic                    w_load;
   logic [DEPTH_LOG2-1:0]   w_index;
   logic [3:0]              w_be;
   logic [31:0]             w_wdata;
   logic [31:0]             w_load_data;
   logic                    w_unused_addr;

   // Select lane(s) of a stored word and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  a,
                                                input logic [1:0]  sz,
                                                input logic        sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b   = 8'h00;
      h   = 16'h0000;
      res = 32'h0000_0000;
      case (sz)
         2'b00: begin
            case (a)
               2'b00:   b = word[7:0];
               2'b01:   b = word[15:8];
               2'b10:   b = word[23:16];
               2'b11:   b = word[31:24];
               default: b = 8'h00;
            endcase
            res = sx ? {{24{b[7]}}, b} : {24'h000000, b};
         end
         2'b01: begin
            h   = a[1] ? word[31:16] : word[15:0];
            res = sx ? {{16{h[15]}}, h} : {16'h0000, h};
         end
         2'b10:   res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Upper address bits alias; fold them into an intentionally unused net.
   assign w_unused_addr = &{1'b0, i_addr[31:DEPTH_LOG2+2]};

   assign w_index  = i_addr[DEPTH_LOG2+1:2];
   assign w_busy   = (r_state == S_CLEAR);
   assign w_ready  = ~w_busy;
   assign w_accept = i_req & w_ready;

   // Misalignment is suppressed during the clear since requests are ignored then.
   assign w_misalign = i_req & ~w_busy &
                       ((i_size == 2'b11) |
                        ((i_size == 2'b01) & i_addr[0]) |
                        ((i_size == 2'b10) & (i_addr[1:0] != 2'b00)));

   assign w_store     = w_accept & i_we & ~w_misalign;
   assign w_load      = w_accept & ~i_we;
   assign w_load_data = w_misalign ? 32'h0000_0000
                                   : load_extract(r_mem[w_index], i_addr[1:0], i_size, i_sext);

   // Lane enables and lane-replicated store data.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = 32'h0000_0000;
      case (i_size)
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_d_in[7:0]}};
         end
         2'b01: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_d_in[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_wdata = i_d_in;
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = 32'h0000_0000;
         end
      endcase
   end

   // State and clear-index registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
      end
   end

   // Next-state: clear walks every index, leaving after the last one is written.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      case (r_state)
         S_CLEAR: begin
            w_next_idx = r_idx + 1'b1;
            if (&r_idx) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_CLEAR;
            end
         end
         S_IDLE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Memory array: clear writes or lane-masked stores; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_busy) begin
         r_mem[r_idx] <= 32'h0000_0000;
      end else if (w_store) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_index][8*k +: 8] <= w_wdata[8*k +: 8];
            end
         end
      end
   end

   generate
      if (READ_REG != 0) begin : g_rd_reg
         logic [31:0] r_d_out;
         logic        r_valid;

         // Registered read port: d_out holds its last load result.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_d_out <= 32'h0000_0000;
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_load;
               if (w_load) begin
                  r_d_out <= w_load_data;
               end
            end
         end

         assign o_d_out = r_d_out;
         assign o_valid = r_valid;
      end else begin : g_rd_comb
         assign o_d_out = w_load ? w_load_data : 32'h0000_0000;
         assign o_valid = w_load;
      end
   endgenerate

   assign o_misalign = w_misalign;
   assign o_ready    = w_ready;
   assign o_busy     = w_busy;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Table-driven bench. Two instances share the stimulus: one with a
//   combinational read port and one with a registered read port. Expected
//   values are hand-computed in the vector tables.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

   typedef struct {
      logic        req;
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] d_in;
      logic [31:0] exp_dout;
      logic        exp_valid;
      logic        exp_mis;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] addr;
   logic [31:0] d_in;

   logic [31:0] c_dout, r_dout;
   logic        c_valid, r_valid;
   logic        c_mis, r_mis;
   logic        c_ready, r_ready;
   logic        c_busy, r_busy;

   int          n_cmp;
   int          n_bad;
   logic [31:0] last_r;

   vec_t tv1 [23];
   vec_t tv2 [4];

   data_mem_ctrl #(.DEPTH_LOG2(8), .READ_REG(0), .CLEAR_ON_RESET(1)) u_comb (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
      .i_sext(sext), .i_addr(addr), .i_d_in(d_in),
      .o_d_out(c_dout), .o_valid(c_valid), .o_misalign(c_mis),
      .o_ready(c_ready), .o_busy(c_busy)
   );

   data_mem_ctrl #(.DEPTH_LOG2(8), .READ_REG(1), .CLEAR_ON_RESET(1)) u_reg (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
      .i_sext(sext), .i_addr(addr), .i_d_in(d_in),
      .o_d_out(r_dout), .o_valid(r_valid), .o_misalign(r_mis),
      .o_ready(r_ready), .o_busy(r_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rq, input logic w, input logic [1:0] sz,
                               input logic sx, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] ed, input logic ev, input logic em);
      vec_t v;
      v.req = rq; v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.d_in = d;
      v.exp_dout = ed; v.exp_valid = ev; v.exp_mis = em;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; leaves at the next posedge+1.
   task automatic apply(input vec_t v, input string nm);
      req = v.req; we = v.we; size = v.size; sext = v.sext; addr = v.addr; d_in = v.d_in;
      #3;
      chk({nm, " comb d_out"}, c_dout, v.exp_dout);
      chk({nm, " comb valid"}, {31'd0, c_valid}, {31'd0, v.exp_valid});
      chk({nm, " comb misalign"}, {31'd0, c_mis}, {31'd0, v.exp_mis});
      chk({nm, " reg misalign"}, {31'd0, r_mis}, {31'd0, v.exp_mis});
      @(posedge clk);
      #1;
      if (v.exp_valid) last_r = v.exp_dout;
      chk({nm, " reg valid"}, {31'd0, r_valid}, {31'd0, v.exp_valid});
      chk({nm, " reg d_out"}, r_dout, last_r);
   endtask

   // Count rising edges with busy high; a store is held on the inputs throughout.
   task automatic wait_clear(input string nm);
      int cnt;
      cnt = 0;
      while (c_busy && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({nm, " busy cycles"}, cnt, 32'd256);
      chk({nm, " reg busy"}, {31'd0, r_busy}, 32'd0);
      chk({nm, " ready"}, {30'd0, c_ready, r_ready}, 32'd3);
      req = 1'b0; we = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; last_r = 32'h0;
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; sext = 1'b0;
      addr = 32'h0; d_in = 32'h0;

      //              req  we   size   sx    addr          d_in          exp_dout      v     mis
      tv1[0]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
      tv1[1]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h43214312, 32'h0000_0000, 1'b0, 1'b0);
      tv1[2]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h43214312, 1'b1, 1'b0);
      tv1[3]  = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h000000FF, 32'h0000_0000, 1'b0, 1'b0);
      tv1[4]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h4321FF12, 1'b1, 1'b0);
      tv1[5]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0);
      tv1[6]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0,        32'h000000FF, 1'b1, 1'b0);
      tv1[7]  = mk(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h00008001, 32'h0000_0000, 1'b0, 1'b0);
      tv1[8]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0,        32'hFFFF8001, 1'b1, 1'b0);
      tv1[9]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h8001FF12, 1'b1, 1'b0);
      tv1[10] = mk(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h00001234, 32'h0000_0000, 1'b0, 1'b1);
      tv1[11] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h8001FF12, 1'b1, 1'b0);
      tv1[12] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0000_0000, 1'b1, 1'b1);
      tv1[13] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 1'b0);
      tv1[14] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
      tv1[15] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0003, 32'h0,        32'h0000_0000, 1'b0, 1'b0);
      tv1[16] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0,        32'h00008001, 1'b1, 1'b0);
      tv1[17] = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0,        32'hFFFFFF12, 1'b1, 1'b0);
      tv1[18] = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0,        32'h00000080, 1'b1, 1'b0);
      tv1[19] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0004, 32'h0,        32'h00000012, 1'b1, 1'b0);
      tv1[20] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,        32'h0000_0000, 1'b1, 1'b1);
      tv1[21] = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0403, 32'h00000055, 32'h0000_0000, 1'b0, 1'b0);
      tv1[22] = mk(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0,        32'h55ADBEEF, 1'b1, 1'b0);

      // After a mid-clear reset every word reads back as zero.
      tv2[0]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
      tv2[1]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
      tv2[2]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
      tv2[3]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0,        32'h0000_0000, 1'b1, 1'b0);

      // Reset state
      #2;
      chk("rst busy", {30'd0, c_busy, r_busy}, 32'd3);
      chk("rst ready", {30'd0, c_ready, r_ready}, 32'd0);
      chk("rst valid", {30'd0, c_valid, r_valid}, 32'd0);
      chk("rst reg d_out", r_dout, 32'h0);
      chk("rst comb d_out", c_dout, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First clear, with an all-ones store to 0x14 held (must be ignored).
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h14; d_in = 32'hFFFF_FFFF;
      #1;
      chk("busy store misalign", {30'd0, c_mis, r_mis}, 32'd0);
      chk("busy store valid", {30'd0, c_valid, r_valid}, 32'd0);
      wait_clear("clear1");

      for (int i = 0; i < 23; i++) apply(tv1[i], $sformatf("v%0d", i));

      // Reset while idle clears output registers.
      rst = 1'b1;
      #1;
      last_r = 32'h0;
      chk("rst2 busy", {30'd0, c_busy, r_busy}, 32'd3);
      chk("rst2 reg valid/d_out", {r_valid, r_dout[30:0]} | {1'b0, 31'(r_dout[31])}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      // Clear index is now 100: restart it.
      rst = 1'b1;
      #1;
      chk("rst3 busy", {30'd0, c_busy, r_busy}, 32'd3);
      #1;
      rst = 1'b0;
      req = 1'b1; we = 1'b0; size = 2'b11; addr = 32'h3;
      #1;
      chk("busy illegal misalign", {30'd0, c_mis, r_mis}, 32'd0);
      chk("busy load valid", {30'd0, c_valid, r_valid}, 32'd0);
      we = 1'b1; size = 2'b10; addr = 32'h8; d_in = 32'hA5A5_A5A5;
      wait_clear("clear2");
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) apply(tv2[i], $sformatf("p%0d", i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
